// File: rtl/tecmo_adpcm_player_if.sv
// ROM fetch handshake between the ADPCM sample player and the sample ROM.
// The player holds rom_cs with a stable rom_addr until the ROM answers with
// rom_ok and a valid rom_data byte in the same cycle.
interface tecmo_adpcm_player_if #(
  parameter int AW = 16
);

  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;

  // Player side: issues requests, receives data.
  modport master (
    output rom_addr,
    output rom_cs,
    input  rom_data,
    input  rom_ok
  );

  // ROM side: answers requests.
  modport slave (
    input  rom_addr,
    input  rom_cs,
    output rom_data,
    output rom_ok
  );

endinterface

// File: rtl/tecmo_adpcm_player.sv
// ADPCM sample feeder for an MSM5205-compatible decoder.
// Walks a ROM region between CPU-programmed start and end pages, fetching one
// byte per two samples and presenting nibbles high-first on every vclk. The
// decoder is held in reset whenever no sample is playing.
module tecmo_adpcm_player #(
  parameter int AW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_addr,
  input  logic [7:0]            cpu_din,
  input  logic                  vclk,
  tecmo_adpcm_player_if.master  rom,
  output logic [3:0]            adpcm_data,
  output logic                  adpcm_rst,
  output logic                  busy,
  output logic                  underrun
);

  // CPU register map.
  localparam logic [1:0] REG_START = 2'd0;
  localparam logic [1:0] REG_END   = 2'd1;
  localparam logic [1:0] REG_PLAY  = 2'd2;
  localparam logic [1:0] REG_STOP  = 2'd3;

  // IDLE: silent. FIRST: waiting for the first byte. RUN: nibbles flowing.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_RUN
  } state_t;

  // Registered state.
  state_t        r_state;
  logic [7:0]    r_start_page;
  logic [7:0]    r_end_page;
  logic [AW-1:0] r_addr;        // address of the byte being (pre)fetched
  logic [AW-1:0] r_end_excl;    // first address past the sample
  logic          r_cs;
  logic [3:0]    r_cur_lo;      // low nibble of the byte now playing
  logic [7:0]    r_next_byte;   // prefetched byte
  logic          r_next_vld;
  logic          r_lo_phase;    // 1 = low nibble is on adpcm_data
  logic [3:0]    r_data;
  logic          r_underrun;

  // Next-state values.
  state_t        w_state_nxt;
  logic [7:0]    w_start_page_nxt;
  logic [7:0]    w_end_page_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [AW-1:0] w_end_excl_nxt;
  logic          w_cs_nxt;
  logic [3:0]    w_cur_lo_nxt;
  logic [7:0]    w_next_byte_nxt;
  logic          w_next_vld_nxt;
  logic          w_lo_phase_nxt;
  logic [3:0]    w_data_nxt;
  logic          w_underrun_nxt;

  // Decoded strobes and address arithmetic.
  logic          w_play;
  logic          w_stop;
  logic          w_ack;
  logic [AW-1:0] w_start;
  logic [AW-1:0] w_end_excl;
  logic [AW-1:0] w_addr_inc;
  logic          w_inc_at_end;
  logic [7:0]    w_byte;

  assign w_play = cpu_we && (cpu_addr == REG_PLAY);
  assign w_stop = cpu_we && (cpu_addr == REG_STOP);

  // An acknowledge only counts while our own request is outstanding.
  assign w_ack  = rom.rom_ok && r_cs;

  // Page numbers become 256-byte aligned addresses; the end page is played in
  // full, so the exclusive limit is one page past it, wrapping mod 2^AW.
  assign w_start      = AW'({r_start_page, 8'h00});
  assign w_end_excl   = AW'({r_end_page, 8'h00}) + AW'(256);
  assign w_addr_inc   = r_addr + AW'(1);
  assign w_inc_at_end = (w_addr_inc == r_end_excl);

  // A byte landing in the same cycle as the lo->hi strobe is used directly.
  assign w_byte = r_next_vld ? r_next_byte : rom.rom_data;

  // Next-state, fetch and nibble sequencing.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_state_nxt      = r_state;
    w_start_page_nxt = r_start_page;
    w_end_page_nxt   = r_end_page;
    w_addr_nxt       = r_addr;
    w_end_excl_nxt   = r_end_excl;
    w_cs_nxt         = r_cs;
    w_cur_lo_nxt     = r_cur_lo;
    w_next_byte_nxt  = r_next_byte;
    w_next_vld_nxt   = r_next_vld;
    w_lo_phase_nxt   = r_lo_phase;
    w_data_nxt       = r_data;
    w_underrun_nxt   = r_underrun;

    // Page registers only take effect at the next play.
    if (cpu_we && (cpu_addr == REG_START)) w_start_page_nxt = cpu_din;
    if (cpu_we && (cpu_addr == REG_END))   w_end_page_nxt   = cpu_din;

    if (w_play) begin
      // Restart from any state. An in-flight request is abandoned by dropping
      // rom_cs for one cycle; FIRST re-raises it.
      w_state_nxt    = ST_FIRST;
      w_addr_nxt     = w_start;
      w_end_excl_nxt = w_end_excl;
      w_cs_nxt       = !r_cs;
      w_next_vld_nxt = 1'b0;
      w_lo_phase_nxt = 1'b0;
      w_data_nxt     = 4'h0;
      w_underrun_nxt = 1'b0;
    end else if (w_stop) begin
      // Silence at once; underrun stays visible until the next play.
      w_state_nxt    = ST_IDLE;
      w_cs_nxt       = 1'b0;
      w_next_vld_nxt = 1'b0;
      w_lo_phase_nxt = 1'b0;
      w_data_nxt     = 4'h0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // vclk is ignored while silent.
        end

        ST_FIRST: begin
          if (!r_cs) begin
            // Second cycle of a retrigger: issue the request for the start byte.
            w_cs_nxt = 1'b1;
          end else if (w_ack) begin
            // First byte: play its high nibble and start the prefetch.
            w_state_nxt    = ST_RUN;
            w_data_nxt     = rom.rom_data[7:4];
            w_cur_lo_nxt   = rom.rom_data[3:0];
            w_lo_phase_nxt = 1'b0;
            w_addr_nxt     = w_addr_inc;
            w_cs_nxt       = !w_inc_at_end;
          end
        end

        ST_RUN: begin
          // Park a completed prefetch; consumption below may override this.
          if (w_ack) begin
            w_next_byte_nxt = rom.rom_data;
            w_next_vld_nxt  = 1'b1;
            w_cs_nxt        = 1'b0;
          end

          if (vclk) begin
            if (!r_lo_phase) begin
              w_data_nxt     = r_cur_lo;
              w_lo_phase_nxt = 1'b1;
            end else if (r_addr == r_end_excl) begin
              // Whole sample played and nothing was prefetched: go silent.
              w_state_nxt    = ST_IDLE;
              w_cs_nxt       = 1'b0;
              w_lo_phase_nxt = 1'b0;
              w_data_nxt     = 4'h0;
            end else if (r_next_vld || w_ack) begin
              w_data_nxt      = w_byte[7:4];
              w_cur_lo_nxt    = w_byte[3:0];
              w_next_vld_nxt  = 1'b0;
              w_lo_phase_nxt  = 1'b0;
              w_addr_nxt      = w_addr_inc;
              w_cs_nxt        = !w_inc_at_end;
            end else begin
              // Byte late: hold the current nibble, stay in lo phase so the
              // byte is consumed at the next strobe without skipping.
              w_underrun_nxt = 1'b1;
            end
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_cs_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous reset; reset overrides any CPU write.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state      <= ST_IDLE;
      r_start_page <= 8'h00;
      r_end_page   <= 8'h00;
      r_addr       <= '0;
      r_end_excl   <= '0;
      r_cs         <= 1'b0;
      r_cur_lo     <= 4'h0;
      r_next_byte  <= 8'h00;
      r_next_vld   <= 1'b0;
      r_lo_phase   <= 1'b0;
      r_data       <= 4'h0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_page <= w_start_page_nxt;
      r_end_page   <= w_end_page_nxt;
      r_addr       <= w_addr_nxt;
      r_end_excl   <= w_end_excl_nxt;
      r_cs         <= w_cs_nxt;
      r_cur_lo     <= w_cur_lo_nxt;
      r_next_byte  <= w_next_byte_nxt;
      r_next_vld   <= w_next_vld_nxt;
      r_lo_phase   <= w_lo_phase_nxt;
      r_data       <= w_data_nxt;
      r_underrun   <= w_underrun_nxt;
    end
  end

  // Outputs come straight from registers; decoder runs only in RUN.
  assign rom.rom_addr = r_addr;
  assign rom.rom_cs   = r_cs;
  assign adpcm_data   = r_data;
  assign adpcm_rst    = (r_state != ST_RUN);
  assign busy         = (r_state != ST_IDLE);
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_tecmo_adpcm_player.sv
// Testbench for tecmo_adpcm_player: random ROM contents and timing, checked
// against a nibble-stream reference model built from the page range.
module tb_tecmo_adpcm_player;

  localparam int AW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_we;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       vclk;
  logic [3:0] adpcm_data;
  logic       adpcm_rst;
  logic       busy;
  logic       underrun;

  tecmo_adpcm_player_if #(.AW(AW)) rom_if ();

  tecmo_adpcm_player #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .vclk       (vclk),
    .rom        (rom_if),
    .adpcm_data (adpcm_data),
    .adpcm_rst  (adpcm_rst),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // ROM image and counters.
  logic [7:0] mem [0:65535];
  int n_checks = 0;
  int n_fail   = 0;

  // ROM responder state.
  int          rom_cnt, rom_lat, lat_min, lat_rng;
  logic [15:0] rom_req_addr;

  // vclk generator state.
  bit vclk_en;
  int vcnt, vper, vjit;

  // Reference model state.
  logic [7:0] m_start, m_end;
  bit         m_play, m_under, gap_chk;
  logic [3:0] exp_q [$];
  int         idx, acks, nbytes;
  logic       obs_cs, obs_arst;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected nibble stream: every byte from start to end page inclusive,
  // address arithmetic wrapping at 64K, high nibble first.
  task automatic load_sample();
    logic [15:0] a, e;
    logic [7:0]  b;
    a = {m_start, 8'h00};
    e = {m_end, 8'h00} + 16'd256;
    exp_q.delete();
    nbytes = 0;
    do begin
      b = mem[a];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
      a++;
      nbytes++;
    end while (a != e);
  endtask

  // Called just after a rising edge; inputs still show the last cycle's drive.
  task automatic monitor();
    logic ack;
    ack = obs_cs && rom_if.rom_ok;
    if (rst) begin
      check("rst_addr", rom_if.rom_addr, 0);
      check("rst_cs", rom_if.rom_cs, 0);
      check("rst_data", adpcm_data, 0);
      check("rst_arst", adpcm_rst, 1);
      check("rst_busy", busy, 0);
      check("rst_under", underrun, 0);
      m_start = 8'h00; m_end = 8'h00;
      m_play = 0; m_under = 0; gap_chk = 0;
    end else if (cpu_we && cpu_addr == 2'd2) begin
      check("play_addr", rom_if.rom_addr, {m_start, 8'h00});
      check("play_cs", rom_if.rom_cs, !obs_cs);
      check("play_busy", busy, 1);
      check("play_arst", adpcm_rst, 1);
      check("play_under", underrun, 0);
      gap_chk = obs_cs;
      load_sample();
      idx = 0; acks = 0; m_play = 1; m_under = 0;
    end else if (cpu_we && cpu_addr == 2'd3) begin
      check("stop_cs", rom_if.rom_cs, 0);
      check("stop_arst", adpcm_rst, 1);
      check("stop_data", adpcm_data, 0);
      check("stop_busy", busy, 0);
      check("stop_under", underrun, m_under);
      m_play = 0; gap_chk = 0;
    end else begin
      if (cpu_we && cpu_addr == 2'd0) m_start = cpu_din;
      if (cpu_we && cpu_addr == 2'd1) m_end   = cpu_din;
      if (gap_chk) begin
        check("regap_cs", rom_if.rom_cs, 1);
        gap_chk = 0;
      end
      if (m_play) begin
        if (ack) acks++;
        if (obs_arst) begin
          if (ack || !adpcm_rst) begin
            check("first_arst", adpcm_rst, 0);
            check("first_ack", ack, 1);
            check("first_nib", adpcm_data, exp_q[0]);
            idx = 1;
          end
        end else if (vclk) begin
          if (idx == exp_q.size()) begin
            check("end_busy", busy, 0);
            check("end_arst", adpcm_rst, 1);
            check("end_data", adpcm_data, 0);
            check("end_bytes", acks, nbytes);
            m_play = 0;
          end else if (idx % 2 == 0 && acks <= idx / 2) begin
            m_under = 1;
            check("hold_nib", adpcm_data, exp_q[idx-1]);
            check("hold_under", underrun, 1);
          end else begin
            check("nib", adpcm_data, exp_q[idx]);
            check("nib_under", underrun, m_under);
            idx++;
          end
        end
      end else if (vclk) begin
        check("idle_cs", rom_if.rom_cs, 0);
        check("idle_busy", busy, 0);
      end
    end
    obs_cs   = rom_if.rom_cs;
    obs_arst = adpcm_rst;
  endtask

  // ROM responder: answers each stable request after rom_lat cycles.
  task automatic rom_step();
    rom_if.rom_ok   = 1'b0;
    rom_if.rom_data = 8'($urandom);
    if (!rom_if.rom_cs) begin
      rom_cnt = 0;
    end else begin
      if (rom_cnt == 0 || rom_if.rom_addr != rom_req_addr) begin
        rom_req_addr = rom_if.rom_addr;
        rom_cnt = 1;
        rom_lat = lat_min + int'($urandom_range(0, lat_rng));
      end else begin
        rom_cnt++;
      end
      if (rom_cnt >= rom_lat) begin
        rom_if.rom_ok   = 1'b1;
        rom_if.rom_data = mem[rom_if.rom_addr];
        rom_cnt = 0;
      end
    end
  endtask

  task automatic vclk_step();
    vclk = 1'b0;
    if (vclk_en) begin
      if (vcnt <= 0) begin
        vclk = 1'b1;
        vcnt = vper - 1 + int'($urandom_range(0, vjit));
      end else begin
        vcnt--;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
    cpu_we = 1'b0;
    rom_step();
    vclk_step();
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    tick();
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && m_play; i++) tick();
    check({tag, "_done"}, m_play, 0);
  endtask

  task automatic wait_cs(input int budget, input string tag);
    for (int i = 0; i < budget && !rom_if.rom_cs; i++) tick();
    check({tag, "_cs_wait"}, rom_if.rom_cs, 1);
  endtask

  task automatic wait_nibbles(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && idx < n; i++) tick();
    check({tag, "_progress"}, (idx >= n), 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1; cpu_we = 1'b0; cpu_addr = 2'd0; cpu_din = 8'h00; vclk = 1'b0;
    rom_if.rom_ok = 1'b0; rom_if.rom_data = 8'h00;
    rom_cnt = 0; rom_lat = 1; lat_min = 2; lat_rng = 0; rom_req_addr = '0;
    vclk_en = 1'b1; vcnt = 0; vper = 8; vjit = 0;
    m_start = 0; m_end = 0; m_play = 0; m_under = 0; gap_chk = 0;
    idx = 0; acks = 0; nbytes = 0; obs_cs = 0; obs_arst = 1;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single page, fixed 2-cycle ROM latency.
    lat_min = 2; lat_rng = 0; vper = 8; vjit = 0;
    cpu_write(2'd0, 8'h12);
    cpu_write(2'd1, 8'h12);
    cpu_write(2'd2, 8'h00);
    wait_done(20000, "page12");

    // Address wrap across 0xFFFF, random latency and strobe jitter.
    lat_min = 1; lat_rng = 3; vper = 6; vjit = 3;
    cpu_write(2'd0, 8'hFF);
    cpu_write(2'd1, 8'h00);
    cpu_write(2'd2, 8'h00);
    wait_done(20000, "wrap");

    // Slow ROM: underrun, then stop mid-sample and watch it stay quiet.
    lat_min = 40; lat_rng = 0; vper = 16; vjit = 0;
    cpu_write(2'd0, 8'h05);
    cpu_write(2'd1, 8'h05);
    cpu_write(2'd2, 8'h00);
    wait_nibbles(40, 5000, "under");
    check("under_flag", underrun, 1);
    cpu_write(2'd3, 8'h00);
    repeat (100) tick();
    check("stop_quiet_busy", busy, 0);

    // Retrigger: page 0x20 underrunning, then play 0x30 mid-request.
    cpu_write(2'd0, 8'h20);
    cpu_write(2'd1, 8'h20);
    cpu_write(2'd2, 8'h00);
    wait_nibbles(10, 3000, "retrig20");
    cpu_write(2'd0, 8'h30);
    cpu_write(2'd1, 8'h30);
    lat_min = 2; vper = 6;
    wait_cs(200, "retrig");
    cpu_we = 1'b1; cpu_addr = 2'd2; cpu_din = 8'h00;
    rom_if.rom_ok = 1'b1; rom_if.rom_data = 8'h5A;
    tick();
    // Stale acknowledge during the one-cycle gap must be ignored.
    rom_if.rom_ok = 1'b1; rom_if.rom_data = ~mem[16'h3000];
    tick();
    wait_done(10000, "retrig30");

    // Reset colliding with a play write and an acknowledge.
    lat_min = 3; vper = 8;
    cpu_write(2'd0, 8'h40);
    cpu_write(2'd1, 8'h40);
    cpu_write(2'd2, 8'h00);
    wait_nibbles(6, 2000, "rstcol");
    wait_cs(200, "rstcol");
    rst = 1'b1;
    cpu_we = 1'b1; cpu_addr = 2'd2; cpu_din = 8'h00;
    rom_if.rom_ok = 1'b1; rom_if.rom_data = 8'hA5;
    tick();
    rst = 1'b0;
    tick();
    check("rst_cs_stays", rom_if.rom_cs, 0);
    // Page registers cleared by reset: play covers 0x0000..0x00FF.
    cpu_write(2'd2, 8'h00);
    wait_done(10000, "page00");

    // Random ranges and timing.
    for (int r = 0; r < 3; r++) begin
      logic [7:0] s;
      s = 8'($urandom);
      lat_min = int'($urandom_range(1, 6));
      lat_rng = int'($urandom_range(0, 8));
      vper    = int'($urandom_range(4, 10));
      vjit    = int'($urandom_range(0, 3));
      cpu_write(2'd0, s);
      cpu_write(2'd1, s + 8'($urandom_range(0, 1)));
      cpu_write(2'd2, 8'h00);
      wait_done(20000, "rand");
    end

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
